// File: rtl/frame_buf_scheduler.sv
// frame_buf_scheduler: triple-buffer scheduler for the LED frame pipeline.
// Keeps the updater rendering into a back buffer, parks finished frames in a
// ready slot, and flips the display to the newest finished frame on each
// scanout frame start so the display never reads a buffer being written.
module frame_buf_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_start,
  output logic                  update_buf,
  output logic [DATA_WIDTH-1:0] upd_buf_id,
  input  logic                  buf_updated,
  output logic [DATA_WIDTH-1:0] disp_buf_id,
  output logic                  disp_valid,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frames_rendered,
  output logic [CNT_WIDTH-1:0]  frames_dropped
);

  typedef enum logic [1:0] {IDLE, START, WAIT, COMMIT} state_t;

  state_t     state, state_n;
  logic [1:0] disp_idx, ready_idx, render_idx;
  logic [1:0] disp_n, ready_n, render_n;
  logic       ready_valid, ready_valid_n;
  logic       commit;
  logic       flip;

  assign commit = (state == COMMIT);
  // A flip happens when there is something new to show: a parked frame, or
  // the frame committing in this very cycle.
  assign flip   = frame_start && (commit || ready_valid);

  // Next-state logic for the render sequencer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_n = state;
    case (state)
      IDLE:    if (enable) state_n = START;
      START:   state_n = WAIT;
      WAIT:    if (buf_updated) state_n = COMMIT;
      COMMIT:  state_n = enable ? START : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Buffer rotation: commit parks the rendered buffer, frame start shows the
  // newest parked one; when both coincide the commit is applied first.
  always_comb begin
    disp_n        = disp_idx;
    ready_n       = ready_idx;
    render_n      = render_idx;
    ready_valid_n = ready_valid;
    if (commit && frame_start) begin
      disp_n        = render_idx;
      render_n      = ready_idx;
      ready_n       = disp_idx;
      ready_valid_n = 1'b0;
    end else if (commit) begin
      ready_n       = render_idx;
      render_n      = ready_idx;
      ready_valid_n = 1'b1;
    end else if (frame_start && ready_valid) begin
      disp_n        = ready_idx;
      ready_n       = disp_idx;
      ready_valid_n = 1'b0;
    end
  end

  // State, indices and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is assigned with <= so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state           <= IDLE;
      disp_idx        <= 2'd0;
      render_idx      <= 2'd1;
      ready_idx       <= 2'd2;
      ready_valid     <= 1'b0;
      update_buf      <= 1'b0;
      busy            <= 1'b0;
      disp_valid      <= 1'b0;
      upd_buf_id      <= {{(DATA_WIDTH-2){1'b0}}, 2'd1};
      disp_buf_id     <= '0;
      frames_rendered <= '0;
      frames_dropped  <= '0;
    end else begin
      state       <= state_n;
      disp_idx    <= disp_n;
      ready_idx   <= ready_n;
      render_idx  <= render_n;
      ready_valid <= ready_valid_n;
      update_buf  <= (state_n == START);
      busy        <= (state_n != IDLE);
      upd_buf_id  <= {{(DATA_WIDTH-2){1'b0}}, render_n};
      disp_buf_id <= {{(DATA_WIDTH-2){1'b0}}, disp_n};
      if (flip)
        disp_valid <= 1'b1;
      if (commit)
        frames_rendered <= frames_rendered + CNT_WIDTH'(1);
      if (commit && ready_valid)
        frames_dropped <= frames_dropped + CNT_WIDTH'(1);
    end
  end

endmodule
